// File: rtl/led_drv_pkg.sv
// Shared types for the LED blink driver.
//   led_mode_e  : 2-bit command mode encoding (OFF, ON, BLINK_N, BLINK_FOREVER)
//   led_state_e : driver FSM states (idle, blink on-phase, blink off-phase)
package led_drv_pkg;

  typedef enum logic [1:0] {
    LED_OFF           = 2'b00,
    LED_ON            = 2'b01,
    LED_BLINK_N       = 2'b10,
    LED_BLINK_FOREVER = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PH_ON  = 2'b01,
    S_PH_OFF = 2'b10
  } led_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Tick prescaler: divides the board clock into a periodic one-cycle tick.
//   i_Clk   : board clock
//   i_Rst_n : synchronous reset, active-low
//   i_Clear : restart the count; the first tick follows CLKS_PER_TICK cycles later
//   o_Tick  : one-cycle pulse, every CLKS_PER_TICK cycles after the last clear
module tick_prescaler #(
  parameter int unsigned CLKS_PER_TICK = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned CntW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_TICK - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_Clear || at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The edge that consumes this tick is exactly CLKS_PER_TICK cycles after the clear edge.
  assign o_Tick = at_last;

endmodule

// File: rtl/led_blink_driver.sv
// LED blink driver: accepts OFF / ON / BLINK_N / BLINK_FOREVER commands over valid/ready
// and drives one active-high LED pin with timed on/off phases.
//   i_Clk, i_Rst_n : board clock, synchronous active-low reset
//   i_Cmd_Valid    : command present
//   o_Cmd_Ready    : command can be accepted (idle, or running BLINK_FOREVER)
//   i_Cmd_Mode     : led_mode_e encoding
//   i_Cmd_Count    : blink count, BLINK_N only
//   o_LED_1        : registered LED drive
//   o_Busy         : high while a blink sequence runs
//   o_Done         : one-cycle pulse when a BLINK_N sequence ends
module led_blink_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 250000,
  parameter int unsigned TICKS_ON      = 25,
  parameter int unsigned TICKS_OFF     = 25,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Cmd_Valid,
  output logic             o_Cmd_Ready,
  input  logic [1:0]       i_Cmd_Mode,
  input  logic [CNT_W-1:0] i_Cmd_Count,
  output logic             o_LED_1,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int unsigned TicksMax = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int unsigned PhW      = $clog2(TicksMax + 1);
  localparam logic [PhW-1:0] PhOnLast  = PhW'(TICKS_ON - 1);
  localparam logic [PhW-1:0] PhOffLast = PhW'(TICKS_OFF - 1);

  led_state_e       state_q;
  logic [PhW-1:0]   phase_q;
  logic [CNT_W-1:0] rem_q;
  logic             forever_q;
  logic             led_q, ready_q, busy_q, done_q;
  logic             accept, tick;

  assign accept = i_Cmd_Valid && ready_q;

  // Restarting the prescaler on accept aligns the first phase to the accepting edge.
  tick_prescaler #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_prescaler (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Clear(accept),
    .o_Tick (tick)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      rem_q     <= '0;
      forever_q <= 1'b0;
      led_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // A new command takes effect on this edge, including pre-empting BLINK_FOREVER.
        phase_q <= '0;
        unique case (i_Cmd_Mode)
          LED_OFF, LED_ON: begin
            state_q   <= S_IDLE;
            led_q     <= (i_Cmd_Mode == LED_ON);
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            forever_q <= 1'b0;
          end
          LED_BLINK_N: begin
            forever_q <= 1'b0;
            if (i_Cmd_Count == '0) begin
              state_q <= S_IDLE;
              led_q   <= 1'b0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_PH_ON;
              led_q   <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              rem_q   <= i_Cmd_Count;
            end
          end
          LED_BLINK_FOREVER: begin
            state_q   <= S_PH_ON;
            led_q     <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b1;
            forever_q <= 1'b1;
          end
          default: ;
        endcase
      end else if (tick) begin
        unique case (state_q)
          S_PH_ON: begin
            if (phase_q == PhOnLast) begin
              phase_q <= '0;
              state_q <= S_PH_OFF;
              led_q   <= 1'b0;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          S_PH_OFF: begin
            if (phase_q == PhOffLast) begin
              phase_q <= '0;
              if (forever_q || rem_q != CNT_W'(1)) begin
                state_q <= S_PH_ON;
                led_q   <= 1'b1;
                if (!forever_q) begin
                  rem_q <= rem_q - 1'b1;
                end
              end else begin
                state_q <= S_IDLE;
                rem_q   <= '0;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Cmd_Ready = ready_q;
  assign o_LED_1     = led_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;

endmodule

// File: tb/tb_led_blink_driver.sv
module tb_led_blink_driver;
  import led_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_count;
  logic       led, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  led_blink_driver #(
    .CLKS_PER_TICK(4),
    .TICKS_ON     (2),
    .TICKS_OFF    (3),
    .CNT_W        (4)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Cmd_Valid(cmd_valid),
    .o_Cmd_Ready(cmd_ready),
    .i_Cmd_Mode (cmd_mode),
    .i_Cmd_Count(cmd_count),
    .o_LED_1    (led),
    .o_Busy     (busy),
    .o_Done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge; afterwards sample index 0 is visible.
  task automatic send(input logic [1:0] mode, input logic [3:0] count);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = count;
    step();
    cmd_valid = 1'b0;
    cmd_mode  = 2'bxx;
    cmd_count = 4'bxxxx;
  endtask

  initial begin
    int bad, pulses, dones;
    logic prev;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_count = 4'd0;
    step();
    step();
    check("rst_led", led, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // ON held 100 cycles, then OFF
    send(LED_ON, 4'd0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (led !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    check("on_hold_bad_cycles", bad, 0);
    send(LED_OFF, 4'd0);
    check("off_led", led, 0);
    check("off_busy", busy, 0);

    // BLINK_N 3: 8 high / 12 low x3, ON offered mid-run is ignored
    send(LED_BLINK_N, 4'd3);
    bad   = 0;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      if (led !== (((k % 20) < 8) ? 1'b1 : 1'b0)) bad++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (done === 1'b1) dones++;
      if (k == 30) begin
        cmd_valid = 1'b1;
        cmd_mode  = LED_ON;
      end
      if (k == 31) cmd_valid = 1'b0;
      step();
    end
    check("blink3_pattern_bad", bad, 0);
    check("blink3_early_done", dones, 0);
    check("blink3_done", done, 1);
    check("blink3_busy_fall", busy, 0);
    check("blink3_ready", cmd_ready, 1);
    check("blink3_led_end", led, 0);
    step();
    check("blink3_done_1cyc", done, 0);

    // BLINK_N 0
    send(LED_BLINK_N, 4'd0);
    check("blink0_done", done, 1);
    check("blink0_led", led, 0);
    check("blink0_busy", busy, 0);
    step();
    check("blink0_done_1cyc", done, 0);

    // BLINK_FOREVER pre-empted by ON at sample 14 (edge 15, inside PH_OFF)
    send(LED_BLINK_FOREVER, 4'd0);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (led !== ((k < 8) ? 1'b1 : 1'b0) || busy !== 1'b1 || cmd_ready !== 1'b1) bad++;
      if (k < 14) step();
    end
    check("forever_pattern_bad", bad, 0);
    send(LED_ON, 4'd0);
    check("preempt_led", led, 1);
    check("preempt_busy", busy, 0);
    check("preempt_done", done, 0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (led !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("preempt_hold_bad", bad, 0);
    send(LED_OFF, 4'd0);

    // BLINK_N 15: exactly 15 pulses, no wrap
    send(LED_BLINK_N, 4'd15);
    pulses = 0;
    dones  = 0;
    prev   = 1'b0;
    bad    = 0;
    for (int k = 0; k < 300; k++) begin
      if (led === 1'b1 && prev === 1'b0) pulses++;
      if (led !== (((k % 20) < 8) ? 1'b1 : 1'b0)) bad++;
      if (done === 1'b1) dones++;
      prev = led;
      step();
    end
    check("blink15_pattern_bad", bad, 0);
    check("blink15_early_done", dones, 0);
    check("blink15_done", done, 1);
    for (int k = 0; k < 40; k++) begin
      step();
      if (led === 1'b1 && prev === 1'b0) pulses++;
      if (done === 1'b1) dones++;
      prev = led;
    end
    check("blink15_pulses", pulses, 15);
    check("blink15_extra_done", dones, 0);
    check("blink15_busy_end", busy, 0);

    // Reset mid-run aborts BLINK_N 1 without a done
    send(LED_BLINK_N, 4'd1);
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    check("midrst_led", led, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (done !== 1'b0 || led !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_after_bad", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
